// File: rtl/led_breather.sv
`default_nettype none
// ============================================================================
// Module   : led_breather
// Purpose  : Breathing-LED sequencer; PWM ramp/hold FSM with a 4-LED red chase.
// Revision : 1.0
// ============================================================================
module led_breather #(
  parameter int PWM_BITS   = 8,
  parameter int STEP_DIV   = 11719,
  parameter int HOLD_STEPS = 64
) (
  input  logic CLK_IN,
  input  logic RST_N,
  input  logic EN,
  output logic GLED5,
  output logic RLED1,
  output logic RLED2,
  output logic RLED3,
  output logic RLED4
);

  localparam int DIV_W  = (STEP_DIV   > 1) ? $clog2(STEP_DIV)   : 1;
  localparam int HOLD_W = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

  localparam logic [PWM_BITS-1:0] C_MAX       = '1;
  localparam logic [PWM_BITS-1:0] C_ZERO      = '0;
  localparam logic [PWM_BITS-1:0] C_LVL_ONE   = PWM_BITS'(1);
  localparam logic [DIV_W-1:0]    C_DIV_LAST  = DIV_W'(STEP_DIV - 1);
  localparam logic [DIV_W-1:0]    C_DIV_ONE   = DIV_W'(1);
  localparam logic [HOLD_W-1:0]   C_HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);
  localparam logic [HOLD_W-1:0]   C_HOLD_ONE  = HOLD_W'(1);

  typedef enum logic [1:0] {
    RISE    = 2'd0,
    HOLD_HI = 2'd1,
    FALL    = 2'd2,
    HOLD_LO = 2'd3
  } state_t;

  logic [DIV_W-1:0]    r_div_cnt;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [PWM_BITS-1:0] r_level;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [1:0]          r_idx;
  state_t              r_state;
  logic [3:0]          r_red;
  logic                r_green;

  logic                w_step;
  state_t              w_state_nxt;
  logic [PWM_BITS-1:0] w_level_nxt;
  logic [HOLD_W-1:0]   w_hold_nxt;
  logic [1:0]          w_idx_nxt;
  logic                w_pwm_on;
  logic [3:0]          w_red_nxt;

  assign w_step = EN && (r_div_cnt == C_DIV_LAST);

  // Prescaler and PWM counter both freeze while EN is low.
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      r_div_cnt <= '0;
      r_pwm_cnt <= '0;
    end else if (EN) begin
      r_div_cnt <= w_step ? '0 : r_div_cnt + C_DIV_ONE;
      r_pwm_cnt <= r_pwm_cnt + C_LVL_ONE;
    end
  end

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= RISE;
      r_level    <= '0;
      r_hold_cnt <= '0;
      r_idx      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_level    <= w_level_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_idx      <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_level_nxt = r_level;
    w_hold_nxt  = r_hold_cnt;
    w_idx_nxt   = r_idx;
    if (w_step) begin
      unique case (r_state)
        RISE: begin
          // Saturate at MAX; the level never wraps.
          if (r_level != C_MAX) w_level_nxt = r_level + C_LVL_ONE;
          if (r_level >= C_MAX - C_LVL_ONE) begin
            w_state_nxt = HOLD_HI;
            w_hold_nxt  = '0;
          end
        end
        HOLD_HI: begin
          if (r_hold_cnt == C_HOLD_LAST) begin
            w_state_nxt = FALL;
            w_hold_nxt  = '0;
          end else begin
            w_hold_nxt = r_hold_cnt + C_HOLD_ONE;
          end
        end
        FALL: begin
          if (r_level != C_ZERO) w_level_nxt = r_level - C_LVL_ONE;
          if (r_level <= C_LVL_ONE) begin
            w_state_nxt = HOLD_LO;
            w_hold_nxt  = '0;
          end
        end
        HOLD_LO: begin
          if (r_hold_cnt == C_HOLD_LAST) begin
            w_state_nxt = RISE;
            w_hold_nxt  = '0;
            w_idx_nxt   = r_idx + 2'd1;
          end else begin
            w_hold_nxt = r_hold_cnt + C_HOLD_ONE;
          end
        end
        default: w_state_nxt = RISE;
      endcase
    end
  end

  assign w_pwm_on = (r_pwm_cnt < r_level);

  always_comb begin
    w_red_nxt = '0;
    for (int k = 0; k < 4; k++) begin
      w_red_nxt[k] = EN && w_pwm_on && (r_idx == 2'(k));
    end
  end

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      r_red   <= '0;
      r_green <= 1'b0;
    end else begin
      r_red   <= w_red_nxt;
      r_green <= EN && (r_state == HOLD_HI);
    end
  end

  assign RLED1 = r_red[0];
  assign RLED2 = r_red[1];
  assign RLED3 = r_red[2];
  assign RLED4 = r_red[3];
  assign GLED5 = r_green;

endmodule
`default_nettype wire

// File: tb/tb_led_breather.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_breather
// Purpose  : Directed self-checking bench for led_breather (PWM 3b, div 4, hold 2).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_led_breather;

  logic CLK_IN = 1'b0;
  logic RST_N  = 1'b0;
  logic EN     = 1'b0;
  logic GLED5, RLED1, RLED2, RLED3, RLED4;

  led_breather #(
    .PWM_BITS  (3),
    .STEP_DIV  (4),
    .HOLD_STEPS(2)
  ) dut (
    .CLK_IN(CLK_IN),
    .RST_N (RST_N),
    .EN    (EN),
    .GLED5 (GLED5),
    .RLED1 (RLED1),
    .RLED2 (RLED2),
    .RLED3 (RLED3),
    .RLED4 (RLED4)
  );

  always #5 CLK_IN = ~CLK_IN;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int leds();
    return int'({GLED5, RLED4, RLED3, RLED2, RLED1});
  endfunction

  task automatic tick();
    @(posedge CLK_IN);
    #1;
  endtask

  // RLED1 high count per 4-cycle step window over one 72-cycle LED period.
  int grp_exp[18] = '{0, 0, 2, 0, 4, 1, 4, 3, 4, 3, 4, 1, 4, 0, 2, 0, 0, 0};
  int gc[5];
  int tot[5];
  int resume_sum;
  int frozen_or;

  initial begin
    // Reset held with EN high
    RST_N = 1'b0;
    EN    = 1'b1;
    repeat (3) tick();
    chk("reset_outputs", leds(), 0);
    chk("reset_level", int'(dut.r_level), 0);
    RST_N = 1'b1;

    // Four full LED periods: duty sweep, hold/fall/hold-low and the chase
    for (int p = 0; p < 4; p++) begin
      tot = '{default: 0};
      for (int g = 0; g < 18; g++) begin
        gc = '{default: 0};
        for (int c = 0; c < 4; c++) begin
          tick();
          if (p == 0 && g == 0 && c == 2) chk("pre_step_level", int'(dut.r_level), 0);
          gc[0] += int'(RLED1);
          gc[1] += int'(RLED2);
          gc[2] += int'(RLED3);
          gc[3] += int'(RLED4);
          gc[4] += int'(GLED5);
        end
        for (int k = 0; k < 5; k++) tot[k] += gc[k];
        if (p == 0) begin
          chk($sformatf("duty_g%0d", g), gc[0], grp_exp[g]);
          chk($sformatf("gled_g%0d", g), gc[4], (g == 7 || g == 8) ? 4 : 0);
          if (g == 0) chk("first_step_level", int'(dut.r_level), 1);
          if (g == 15) begin
            chk("fall_end_level", int'(dut.r_level), 0);
            chk("fall_end_state", int'(dut.r_state), 3);
          end
        end
      end
      for (int k = 0; k < 4; k++)
        chk($sformatf("chase_p%0d_rled%0d", p, k + 1), tot[k], (k == p) ? 32 : 0);
      chk($sformatf("chase_p%0d_gled", p), tot[4], 8);
    end
    chk("idx_wrap", int'(dut.r_idx), 0);

    resume_sum = 0;
    for (int c = 0; c < 32; c++) begin
      tick();
      resume_sum += int'(RLED1);
    end
    chk("chase_resume_rled1", resume_sum, 14);

    // Async reset during HOLD_HI, then restart
    RST_N = 1'b0;
    repeat (2) tick();
    RST_N = 1'b1;
    repeat (30) tick();
    chk("hold_hi_gled", int'(GLED5), 1);
    #2;
    RST_N = 1'b0;
    #1;
    chk("async_reset_outputs", leds(), 0);
    chk("async_reset_level", int'(dut.r_level), 0);
    tick();
    RST_N = 1'b1;
    repeat (3) tick();
    chk("restart_pre_step_level", int'(dut.r_level), 0);
    tick();
    chk("restart_first_step_level", int'(dut.r_level), 1);

    // Freeze mid-FALL at level 4 (after edge 49, div_cnt = 1)
    repeat (45) tick();
    chk("freeze_entry_level", int'(dut.r_level), 4);
    chk("freeze_entry_state", int'(dut.r_state), 2);
    EN = 1'b0;
    tick();
    chk("freeze_outputs", leds(), 0);
    frozen_or = 0;
    for (int c = 0; c < 19; c++) begin
      tick();
      frozen_or |= leds();
    end
    chk("freeze_outputs_hold", frozen_or, 0);
    chk("freeze_level", int'(dut.r_level), 4);
    chk("freeze_state", int'(dut.r_state), 2);
    EN = 1'b1;
    repeat (2) tick();
    chk("resume_pre_step_level", int'(dut.r_level), 4);
    tick();
    chk("resume_step_level", int'(dut.r_level), 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_breather.md
# led_breather

Breathing-LED sequencer that sits directly downstream of the board's free-running counter/blink stage and drives the five user LEDs with PWM instead of raw counter bits. A prescaler generates brightness-step ticks. A four-state FSM ramps a duty level up, holds it, ramps it down and holds it again. The red LEDs breathe one at a time in a rotating chase; the green LED flags the full-brightness hold.

## Interface
- PWM_BITS, 8, width of PWM counter and duty level; MAX = 2^PWM_BITS-1
- STEP_DIV, 11719, CLK_IN cycles per brightness step (≈0.25 s full ramp at 12 MHz); must be ≥2
- HOLD_STEPS, 64, step ticks spent in each hold state; must be ≥1
- CLK_IN  in  1  system clock, 12 MHz
- RST_N  in  1  reset, asynchronous, active-low
- EN  in  1  run enable; low freezes all state
- GLED5  out  1  green: high during full-brightness hold
- RLED1  out  1  red LED 0 of chase, PWM
- RLED2  out  1  red LED 1 of chase, PWM
- RLED3  out  1  red LED 2 of chase, PWM
- RLED4  out  1  red LED 3 of chase, PWM

## Operation
- **Reset** (RST_N low, async): all outputs 0; div_cnt=0, pwm_cnt=0, level=0, hold_cnt=0, idx=0, state=RISE.
- **Prescaler:** div_cnt counts 0..STEP_DIV-1 while EN=1, then wraps to 0. step = EN & (div_cnt==STEP_DIV-1).
- **PWM counter:** pwm_cnt is PWM_BITS wide. It increments every EN=1 cycle and wraps MAX→0.
- **FSM** (advances only on step):
  - RISE: level+1. On reaching MAX → HOLD_HI, hold_cnt=0.
  - HOLD_HI: hold_cnt+1. When hold_cnt==HOLD_STEPS-1 → FALL, hold_cnt=0.
  - FALL: level-1. On reaching 0 → HOLD_LO, hold_cnt=0.
  - HOLD_LO: hold_cnt+1. When hold_cnt==HOLD_STEPS-1 → RISE, hold_cnt=0, idx=(idx+1) mod 4.
- **Level arithmetic:** level is unsigned, PWM_BITS wide, and never wraps. RISE never increments past MAX; FALL never decrements below 0.
- **Outputs** (registered):
  - RLED(k+1) = (idx==k) & EN & (pwm_cnt < level).
  - GLED5 = EN & (state==HOLD_HI).
  - Inactive red LEDs are held 0.
- **Duty:** level=0 gives constant off. level=L gives exactly L high cycles per 2^PWM_BITS cycles, so MAX yields MAX/2^PWM_BITS (never 100 %).
- **EN low:** all counters, level, idx and state hold their values; all outputs are 0 from the next edge. When EN returns high, operation resumes from the frozen values with no restart.
- **Reset mid-operation:** returns immediately to the reset state; no partial ramp is retained.

## Timing
- Output latency: the LED output reflects pwm_cnt/level/state one CLK_IN edge after they change.
- First step after reset release with EN=1: at the STEP_DIV-th rising edge. level becomes 1 on that edge.
- One LED period = (2·MAX + 2·HOLD_STEPS)·STEP_DIV cycles. The chase period is 4× that.
- idx increments on the same edge as the HOLD_LO→RISE transition. The new LED's first nonzero duty starts one step later.
- No handshake; EN is sampled every edge and is assumed synchronous to CLK_IN.

## Test plan
All scenarios use PWM_BITS=3, STEP_DIV=4, HOLD_STEPS=2 (MAX=7, LED period 72 cycles).
- **Reset and first step.** Hold RST_N low with EN=1 → all outputs 0. Release → level=1 after edge 4; RLED1 then high 1 of every 8 cycles; RLED2–4 and GLED5 stay 0.
- **Duty sweep.** Free-run and sample each level → RLED1 high count per 8-cycle window equals level (0..7). At level 7, high 7/8, never continuously high.
- **Hold, fall and hold-low.** Free-run through one full period:
  - GLED5 high for exactly 8 cycles, starting 28 cycles after reset release.
  - FALL lasts 28 cycles and ends at level 0.
  - HOLD_LO lasts 8 cycles with RLED1 constant 0.
- **Chase wrap.** Run 288 cycles → active LED order RLED1→RLED2→RLED3→RLED4; at cycle 288, idx returns to 0 and RLED1 resumes.
- **Freeze.** Drop EN mid-FALL at level 4 for 20 cycles:
  - All outputs 0 one edge later.
  - level stays 4 and state stays FALL.
  - After EN rises, the next step occurs after the remaining div_cnt count and gives level=3.
- **Async reset mid-hold.** Assert RST_N during HOLD_HI → GLED5 and RLEDs drop to 0 without a clock edge. Release → restart exactly as in scenario 1.
